// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared 16-bit memory port: instruction fetch (0) and data (1).
// Round-robin on ties, fixed-latency access sequencing, one-cycle done pulse with read data.
module mem_port_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  input  logic [15:0] mem_rdata,
  output logic        sel,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] rdata,
  output logic        if_done,
  output logic        dm_done,
  output logic        busy
);

  // Handshake: a requester raises req with stable address/data and holds it
  // until its done pulse; everything is captured at grant, so later changes
  // on that requester's inputs are ignored until the next arbitration.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_C = 4'(LAT);

  state_t     state;
  logic       last_gnt;
  logic [3:0] cnt;

  logic       cand_if;
  logic       cand_dm;
  logic       prev_gnt;
  logic       gnt_any;
  logic       gnt_sel;

  // In RESP the completing requester's req still belongs to the finishing
  // access, so it is masked; only the other side can be granted back-to-back.
  always_comb begin
    cand_if  = 1'b0;
    cand_dm  = 1'b0;
    prev_gnt = last_gnt;
    gnt_any  = 1'b0;
    gnt_sel  = 1'b0;
    if (state == IDLE || state == RESP) begin
      cand_if = if_req && !(state == RESP && sel == 1'b0);
      cand_dm = dm_req && !(state == RESP && sel == 1'b1);
    end
    if (state == RESP) begin
      prev_gnt = sel;
    end
    gnt_any = cand_if || cand_dm;
    if (cand_if && cand_dm) begin
      gnt_sel = ~prev_gnt;
    end else begin
      gnt_sel = cand_dm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b0;
      cnt       <= 4'd0;
      sel       <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      rdata     <= 16'h0000;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      rdata   <= 16'h0000;
      case (state)
        IDLE, RESP: begin
          if (state == RESP) begin
            last_gnt <= sel;
          end
          if (gnt_any) begin
            sel       <= gnt_sel;
            mem_addr  <= gnt_sel ? dm_addr : if_addr;
            mem_wdata <= gnt_sel ? dm_wdata : 16'h0000;
            mem_wr    <= gnt_sel & dm_wr;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ISSUE: begin
          cnt   <= LAT_C;
          busy  <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          busy <= 1'b1;
          cnt  <= cnt - 4'd1;
          // cnt hitting zero at this edge marks the data-valid cycle
          if (cnt <= 4'd1) begin
            rdata   <= mem_rdata;
            if_done <= ~sel;
            dm_done <= sel;
            state   <= RESP;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a single-request vector table plus
// hand-written sequences for ties, round robin, dropped requests, reset abort and LAT=1.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] mem_rdata;

  logic        sel, mem_en, mem_wr, if_done, dm_done, busy;
  logic [15:0] mem_addr, mem_wdata, rdata;
  logic        sel_1, mem_en_1, mem_wr_1, if_done_1, dm_done_1, busy_1;
  logic [15:0] mem_addr_1, mem_wdata_1, rdata_1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_rdata(mem_rdata), .sel(sel), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rdata(rdata),
    .if_done(if_done), .dm_done(dm_done), .busy(busy)
  );

  mem_port_arbiter #(.LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_rdata(mem_rdata), .sel(sel_1), .mem_en(mem_en_1), .mem_wr(mem_wr_1),
    .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .rdata(rdata_1),
    .if_done(if_done_1), .dm_done(dm_done_1), .busy(busy_1)
  );

  typedef struct {
    logic        use_dm;
    logic        wr_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        exp_sel;
    logic        exp_wr;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[4];

  // One cycle: move past the edge, then present a fresh memory read value.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = 16'hA000 + 16'(cyc);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_outs"}, {15'd0, sel, mem_en, mem_wr, if_done, dm_done, busy}, 16'h0);
    check({name, "_addr"}, mem_addr, 16'h0);
    check({name, "_wdata"}, mem_wdata, 16'h0);
    check({name, "_rdata"}, rdata, 16'h0);
  endtask

  logic [15:0] exp_rd;
  int          n_issue;
  int          both_done;
  int          en_cnt;
  int          done_cnt;
  logic        gsel[6];
  int          gcyc[6];

  initial begin
    mem_rdata = 16'h0;
    vecs[0] = '{1'b0, 1'b1, 16'h0040, 16'h1111, 1'b0, 1'b0, 16'h0040, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h2000, 16'h5555, 1'b1, 1'b0, 16'h2000, 16'h5555};
    vecs[2] = '{1'b1, 1'b1, 16'hFFFE, 16'hBEEF, 1'b1, 1'b1, 16'hFFFE, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h7777, 1'b0, 1'b0, 16'hFFFF, 16'h0000};

    do_reset();
    check_idle_outputs("reset");
    check("reset_lat1", {11'd0, sel_1, mem_en_1, if_done_1, dm_done_1, busy_1}, 16'h0);

    // Single-requester table: fetch ignores dm_wr/dm_wdata, the other address is a decoy.
    for (int i = 0; i < 4; i++) begin
      dm_wr    = vecs[i].wr_in;
      dm_wdata = vecs[i].wdata_in;
      if (vecs[i].use_dm) begin
        dm_req = 1'b1; dm_addr = vecs[i].addr_in; if_addr = ~vecs[i].addr_in;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr_in; dm_addr = ~vecs[i].addr_in;
      end
      tick();
      check($sformatf("v%0d_issue", i), {12'd0, mem_en, busy, sel, mem_wr},
            {12'd0, 1'b1, 1'b1, vecs[i].exp_sel, vecs[i].exp_wr});
      check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
      if_addr = 16'h0BAD; dm_addr = 16'h0BAD; dm_wdata = 16'h0BAD;
      tick();
      check($sformatf("v%0d_wait", i), {14'd0, mem_en, if_done | dm_done}, 16'h0);
      tick();
      exp_rd = mem_rdata;
      tick();
      check($sformatf("v%0d_done", i), {14'd0, if_done, dm_done},
            {14'd0, ~vecs[i].use_dm, vecs[i].use_dm});
      check($sformatf("v%0d_hold", i), mem_addr, vecs[i].exp_addr);
      if (!vecs[i].exp_wr) check($sformatf("v%0d_rdata", i), rdata, exp_rd);
      if_req = 1'b0; dm_req = 1'b0;
      tick();
      check($sformatf("v%0d_idle", i), {13'd0, busy, if_done, dm_done}, 16'h0);
    end

    // Tie right after reset: data first, then fetch issued in the cycle after RESP.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0100;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h1234; dm_wdata = 16'hBEEF;
    tick();
    check("tie_sel", {14'd0, sel, mem_wr}, 16'h0003);
    check("tie_addr", mem_addr, 16'h1234);
    check("tie_wdata", mem_wdata, 16'hBEEF);
    tick(); tick(); tick();
    check("tie_dm_done", {14'd0, if_done, dm_done}, 16'h0001);
    dm_req = 1'b0;
    tick();
    check("tie_fetch_issue", {13'd0, mem_en, sel, mem_wr}, 16'h0004);
    check("tie_fetch_addr", mem_addr, 16'h0100);
    tick(); tick(); tick();
    check("tie_if_done", {14'd0, if_done, dm_done}, 16'h0002);
    if_req = 1'b0;
    tick();

    // Both held high: alternating grants, one issue every LAT+2 cycles.
    do_reset();
    if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b0;
    n_issue = 0; both_done = 0;
    for (int c = 0; c < 60 && n_issue < 6; c++) begin
      tick();
      if (if_done && dm_done) both_done++;
      if (mem_en) begin
        gsel[n_issue] = sel;
        gcyc[n_issue] = cyc;
        n_issue++;
      end
    end
    check("rr_issue_count", 16'(n_issue), 16'd6);
    for (int i = 0; i < n_issue; i++) begin
      check($sformatf("rr_order%0d", i), {15'd0, gsel[i]}, (i % 2 == 0) ? 16'd1 : 16'd0);
      if (i > 0) check($sformatf("rr_spacing%0d", i), 16'(gcyc[i] - gcyc[i-1]), 16'd4);
    end
    check("rr_no_double_done", 16'(both_done), 16'd0);

    // Data request dropped after ISSUE still completes exactly once.
    do_reset();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0300;
    tick();
    check("drop_issue", {14'd0, mem_en, sel}, 16'h0003);
    tick();
    dm_req = 1'b0;
    en_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_en) en_cnt++;
      if (dm_done) done_cnt++;
      tick();
    end
    check("drop_done_once", 16'(done_cnt), 16'd1);
    check("drop_no_reissue", 16'(en_cnt), 16'd0);

    // Reset in WAIT after a completed data access: abort, no done, data wins next tie.
    do_reset();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0500;
    tick(); tick(); tick(); tick();
    check("abort_pre_done", {15'd0, dm_done}, 16'h1);
    dm_req = 1'b0;
    tick();
    dm_req = 1'b1;
    tick(); tick();
    check("abort_in_wait", {14'd0, busy, mem_en}, 16'h0002);
    rst = 1'b1;
    tick();
    rst = 1'b0; dm_req = 1'b0;
    check_idle_outputs("abort");
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if_done || dm_done || busy) done_cnt++;
    end
    check("abort_quiet", 16'(done_cnt), 16'd0);
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 16'h0600; if_addr = 16'h0700;
    tick();
    check("abort_tie_sel", {15'd0, sel}, 16'h1);
    check("abort_tie_addr", mem_addr, 16'h0600);

    // LAT=1 instance: mem_en at T+1, capture at T+2, done at T+3.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0040;
    tick();
    check("lat1_issue", {14'd0, mem_en_1, sel_1}, 16'h0002);
    check("lat1_addr", mem_addr_1, 16'h0040);
    tick();
    exp_rd = mem_rdata;
    check("lat1_wait", {15'd0, if_done_1}, 16'h0);
    tick();
    check("lat1_done", {14'd0, if_done_1, dm_done_1}, 16'h0002);
    check("lat1_rdata", rdata_1, exp_rd);
    if_req = 1'b0;
    tick();
    check("lat1_after", {15'd0, if_done_1}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
